// File: rtl/regfile_write_queue.sv
// Write-side FIFO in front of the register bank: buffers (addr, data) writes and drains one per cycle
// as a one-hot write enable plus shared data. Define REGFILE_WQ_COALESCE_EN to merge same-address writes.
module regfile_write_queue #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_data,
    input  logic                    drain_en,
    input  logic                    flush,
    output logic [NUM_REGS-1:0]     reg_wen,
    output logic [DATA_W-1:0]       reg_in,
    output logic [NUM_REGS-1:0]     pending_mask,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two in 2..16");
    end
    if (NUM_REGS < 2 || NUM_REGS > 16) begin : g_bad_num_regs
        $error("NUM_REGS must be in 2..16");
    end

    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NUM_REGS-1:0] reg_wen_q, reg_wen_d;
    logic [DATA_W-1:0]   reg_in_q, reg_in_d;

    logic full, push, pop, coalesce, alloc;

    // Out-of-range addresses decode to an all-zero enable.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < NUM_REGS; j++) begin
            if (32'(a) == j) begin
                v[j] = 1'b1;
            end
        end
        return v;
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign req_ready = rst && !flush && !full;
    assign push      = req_valid && req_ready;
    assign pop       = (count_q != '0) && drain_en && !flush;

`ifdef REGFILE_WQ_COALESCE_EN
    logic [PTR_W-1:0] newest;

    assign newest   = tail_q - PTR_W'(1);
    // The newest entry may only absorb a write if it is not leaving the queue this cycle.
    assign coalesce = push && (count_q != '0) && (addr_q[newest] == req_addr) &&
                      ((count_q > CNT_W'(1)) || !drain_en);
`else
    assign coalesce = 1'b0;
`endif

    assign alloc = push && !coalesce;

    // Entry storage needs no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail_q] <= req_addr;
            data_q[tail_q] <= req_data;
        end
`ifdef REGFILE_WQ_COALESCE_EN
        else if (coalesce) begin
            data_q[newest] <= req_data;
        end
`endif
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        reg_wen_d = '0;
        reg_in_d  = reg_in_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d    = head_q + PTR_W'(1);
                reg_wen_d = onehot(addr_q[head_q]);
                reg_in_d  = data_q[head_q];
            end
            unique case ({alloc, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            reg_wen_q <= '0;
            reg_in_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            reg_wen_q <= reg_wen_d;
            reg_in_q  <= reg_in_d;
        end
    end

    // Hazard mask covers every occupied slot plus the write currently on the bank.
    always_comb begin
        pending_mask = reg_wen_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                pending_mask = pending_mask | onehot(addr_q[head_q + PTR_W'(i)]);
            end
        end
    end

    assign reg_wen = reg_wen_q;
    assign reg_in  = reg_in_q;
    assign count   = count_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: queue-based reference model checked every cycle, plus directed
// literal checks; a second instance with NUM_REGS=10 covers out-of-range addresses.
module tb_regfile_write_queue;

    localparam int DEPTH = 4;
`ifdef REGFILE_WQ_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       drain_en = 1'b0;
    logic       flush = 1'b0;
    logic       req_ready;
    logic [7:0] reg_wen, reg_in, pending_mask;
    logic [2:0] count;

    logic       o_valid = 1'b0;
    logic [3:0] o_addr = '0;
    logic [7:0] o_data = '0;
    logic       o_drain = 1'b0;
    logic       o_flush = 1'b0;
    logic       o_ready;
    logic [9:0] o_wen, o_pm;
    logic [7:0] o_in;
    logic [2:0] o_count;

    int total = 0;
    int bad = 0;

    regfile_write_queue u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .drain_en(drain_en), .flush(flush),
        .reg_wen(reg_wen), .reg_in(reg_in), .pending_mask(pending_mask), .count(count)
    );

    regfile_write_queue #(.NUM_REGS(10)) u_oor (
        .clk(clk), .rst(rst), .req_valid(o_valid), .req_ready(o_ready),
        .req_addr(o_addr), .req_data(o_data), .drain_en(o_drain), .flush(o_flush),
        .reg_wen(o_wen), .reg_in(o_in), .pending_mask(o_pm), .count(o_count)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] m_wen = '0;
    logic [7:0] m_in = '0;

    // Reference model: an ordered list of pending writes, updated per clock edge.
    initial begin : model
        bit   do_push, do_pop, merge;
        ent_t e;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq.delete();
                m_wen = '0;
                m_in  = '0;
            end else if (flush) begin
                mq.delete();
                m_wen = '0;
            end else begin
                do_push = req_valid && (mq.size() < DEPTH);
                do_pop  = (mq.size() > 0) && drain_en;
                merge   = 1'b0;
`ifdef REGFILE_WQ_COALESCE_EN
                merge = do_push && (mq.size() > 0) && (mq[$].addr == req_addr) &&
                        ((mq.size() > 1) || !drain_en);
`endif
                if (do_pop) begin
                    e     = mq.pop_front();
                    m_wen = 8'(1) << e.addr;
                    m_in  = e.data;
                end else begin
                    m_wen = '0;
                end
                if (merge) begin
                    mq[mq.size() - 1].data = req_data;
                end else if (do_push) begin
                    mq.push_back('{addr: req_addr, data: req_data});
                end
            end
        end
    end

    initial begin : compare
        logic [7:0] exp_pm;
        forever begin
            @(negedge clk);
            exp_pm = m_wen;
            foreach (mq[i]) exp_pm = exp_pm | (8'(1) << mq[i].addr);
            chk("m_ready", 32'(req_ready), 32'(rst && !flush && (mq.size() < DEPTH)));
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_wen", 32'(reg_wen), 32'(m_wen));
            chk("m_in", 32'(reg_in), 32'(m_in));
            chk("m_pending", 32'(pending_mask), 32'(exp_pm));
        end
    end

    initial begin : stim
        repeat (2) step();
        chk("rst_count", 32'(count), 0);
        chk("rst_wen", 32'(reg_wen), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 1);

        // Single write with latency check
        drain_en = 1'b1;
        req_valid = 1'b1; req_addr = 3; req_data = 8'h5C;
        step();
        req_valid = 1'b0;
        chk("t1_count", 32'(count), 1);
        chk("t1_pend", 32'(pending_mask), 32'h08);
        chk("t1_wen0", 32'(reg_wen), 0);
        step();
        chk("t1_wen", 32'(reg_wen), 32'h08);
        chk("t1_in", 32'(reg_in), 32'h5C);
        chk("t1_pend2", 32'(pending_mask), 32'h08);
        step();
        chk("t1_wen_clr", 32'(reg_wen), 0);
        chk("t1_pend_clr", 32'(pending_mask), 0);

        // Fill to full with drain stalled, then drain in order
        drain_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 3'(i); req_data = 8'(8'h10 + i);
            #1;
            chk("t2_ready", 32'(req_ready), (i < 4) ? 1 : 0);
            step();
        end
        req_valid = 1'b0;
        chk("t2_count", 32'(count), 4);
        chk("t2_pend", 32'(pending_mask), 32'h0F);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_wen", 32'(reg_wen), 32'(1) << i);
            chk("t2_in", 32'(reg_in), 32'h10 + i);
        end
        step();
        chk("t2_done", 32'(count), 0);

        // Same-register back-to-back while draining
        req_valid = 1'b1; req_addr = 2; req_data = 8'h0A;
        step();
        req_data = 8'h0B;
        step();
        req_valid = 1'b0;
        chk("t3_wen_a", 32'(reg_wen), 32'h04);
        chk("t3_in_a", 32'(reg_in), 32'h0A);
        step();
        chk("t3_wen_b", 32'(reg_wen), 32'h04);
        chk("t3_in_b", 32'(reg_in), 32'h0B);
        step();

        // Same-register with drain stalled (coalesce candidate)
        drain_en = 1'b0;
        req_valid = 1'b1; req_addr = 2; req_data = 8'h0A;
        step();
        req_data = 8'h0B;
        step();
        req_valid = 1'b0;
        chk("t3c_count", 32'(count), COAL ? 1 : 2);
        drain_en = 1'b1;
        step();
        chk("t3c_wen", 32'(reg_wen), 32'h04);
        chk("t3c_in", 32'(reg_in), COAL ? 32'h0B : 32'h0A);
        step();
        chk("t3c_wen2", 32'(reg_wen), COAL ? 0 : 32'h04);
        chk("t3c_in2", 32'(reg_in), 32'h0B);
        step();

        // Flush discards queued writes and blocks a concurrent push
        drain_en = 1'b0;
        for (int i = 5; i < 8; i++) begin
            req_valid = 1'b1; req_addr = 3'(i); req_data = 8'(8'h50 + i);
            step();
        end
        chk("t4_count", 32'(count), 3);
        chk("t4_pend", 32'(pending_mask), 32'hE0);
        flush = 1'b1;
        #1;
        chk("t4_ready", 32'(req_ready), 0);
        step();
        flush = 1'b0; req_valid = 1'b0;
        chk("t4_count0", 32'(count), 0);
        chk("t4_pend0", 32'(pending_mask), 0);
        drain_en = 1'b1;
        step();
        step();
        chk("t4_wen", 32'(reg_wen), 0);

        // Asynchronous reset mid-operation
        drain_en = 1'b0;
        for (int i = 4; i < 7; i++) begin
            req_valid = 1'b1; req_addr = 3'(i); req_data = 8'(8'h40 + i);
            step();
        end
        req_valid = 1'b0; drain_en = 1'b1;
        step();
        chk("t5_wen", 32'(reg_wen), 32'h10);
        chk("t5_count", 32'(count), 2);
        drain_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("t5_wen_async", 32'(reg_wen), 0);
        chk("t5_count_async", 32'(count), 0);
        chk("t5_pend_async", 32'(pending_mask), 0);
        chk("t5_ready_low", 32'(req_ready), 0);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_ready", 32'(req_ready), 1);
        chk("t5_in", 32'(reg_in), 0);

        // Out-of-range address on the NUM_REGS=10 instance
        o_valid = 1'b1; o_addr = 12; o_data = 8'h77;
        step();
        chk("t6_count1", 32'(o_count), 1);
        chk("t6_pend1", 32'(o_pm), 0);
        o_addr = 9; o_data = 8'h99;
        step();
        o_valid = 1'b0;
        chk("t6_count2", 32'(o_count), 2);
        chk("t6_pend2", 32'(o_pm), 32'h200);
        o_drain = 1'b1;
        step();
        chk("t6_wen_oor", 32'(o_wen), 0);
        chk("t6_in_oor", 32'(o_in), 32'h77);
        chk("t6_count3", 32'(o_count), 1);
        step();
        chk("t6_wen9", 32'(o_wen), 32'h200);
        chk("t6_in9", 32'(o_in), 32'h99);
        chk("t6_count4", 32'(o_count), 0);
        step();
        chk("t6_pend_end", 32'(o_pm), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side buffer directly upstream of the 8-bit `register` instances that make up the processor register bank.
- Accepts (address, data) write requests from the execute/writeback stage over a valid/ready handshake and holds them in a small FIFO.
- Drains one entry per cycle into the bank as a one-hot per-register write enable plus a shared data bus.
- Exposes a pending-write mask so decode can detect read-after-write hazards.

Parameters:
- DATA_W, 8, width of register data.
- NUM_REGS, 8, number of registers in the bank (2..16).
- DEPTH, 4, FIFO entries (power of two, 2..16).
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  write request present.
- req_ready  output  1  queue can accept a request this cycle.
- req_addr  input  ADDR_W  destination register index.
- req_data  input  DATA_W  write data.
- drain_en  input  1  bank may be written this cycle; 0 stalls draining.
- flush  input  1  synchronous discard of all queued writes.
- reg_wen  output  NUM_REGS  one-hot write enables, one bit to each register's wen.
- reg_in  output  DATA_W  shared data to every register's in.
- pending_mask  output  NUM_REGS  bit i = a write to register i is queued or on reg_wen.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO pointers and count are 0; reg_wen = 0; reg_in = 0; pending_mask = 0.
  - req_ready = 0 while rst is low.
- req_ready = !flush && (count < DEPTH). It is combinational and does not depend on req_valid.
- Push occurs on the rising edge when req_valid && req_ready. The entry is stored at tail, and tail and count increment.
- No full-bypass: when count == DEPTH, req_ready = 0 even if a pop occurs in the same cycle.
- Pop occurs on the rising edge when count > 0 && drain_en && !flush. Each pop:
  - sets reg_wen to onehot(head.addr) and reg_in to head.data (both registered);
  - advances head and decrements count.
- In every other cycle reg_wen is 0 and reg_in holds its last value.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Latency from empty:
  - request accepted at edge N;
  - popped at edge N+1, so reg_wen is valid during cycle N+1..N+2;
  - register captures at edge N+2.
- Throughput: 1 write/cycle sustained when drain_en = 1.
- Order: writes reach the bank strictly in acceptance order. Back-to-back writes to the same register leave the last one in the register.
- Address out of range (req_addr >= NUM_REGS):
  - the entry is accepted and occupies a slot;
  - its pop produces reg_wen = 0 and does not affect pending_mask.
- Pointers wrap modulo DEPTH. Count spans 0..DEPTH.
- flush (synchronous):
  - on the edge, count, head and tail go to 0 and reg_wen goes to 0;
  - a push in the same cycle is blocked because req_ready is 0.
- drain_en low with count > 0: no pop, reg_wen = 0, entries retained.
- Reset asserted mid-operation: all queued writes are discarded immediately and reg_wen drops asynchronously.
- pending_mask = OR of onehot(addr) over all valid queue entries, OR current reg_wen. It is combinational from state.

Optional Feature:
- REGFILE_WQ_COALESCE_EN: when defined, an accepted request whose req_addr equals the newest queued entry's address overwrites that entry's data. In that case no new slot is used and tail and count are unchanged.
- Coalescing applies only if count > 0 and that entry is not being popped in the same cycle (count > 1 or !drain_en).
- When the macro is undefined, every accepted request occupies a new slot.

Test Plan:
- Reset release, then req 3/0x5C with drain_en = 1 → count 1 after the edge; the next edge gives reg_wen = 8'b0000_1000 and reg_in = 0x5C for one cycle; pending_mask bit 3 is set until reg_wen clears.
- drain_en = 0, push 5 requests back-to-back (addresses 0..3, then 4) → the first 4 are accepted, count = 4, req_ready = 0 on the 5th; raise drain_en → reg_wen sequence 0x01, 0x02, 0x04, 0x08 on consecutive cycles with the matching data.
- Push 2/0x0A and 2/0x0B with drain_en = 1 → two consecutive reg_wen = 0x04 with reg_in 0x0A then 0x0B; with REGFILE_WQ_COALESCE_EN and drain_en = 0, count stays 1 and the single drain gives 0x0B.
- Queue 3 entries with drain_en = 0, assert flush for one cycle → count = 0, pending_mask = 0, reg_wen remains 0 after drain_en rises.
- Pull rst low while count = 2 and reg_wen = 0x10 → reg_wen, count and pending_mask are 0 immediately (before the next clock edge); after release, req_ready = 1.
- req_addr = 9 with NUM_REGS = 8 (ADDR_W = 4 override disallowed; test with NUM_REGS = 10 and addr 12) → entry accepted, its pop gives reg_wen = 0, count decrements.
